// File: rtl/rptr_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rptr_ctrl_pkg
// Shared definitions for the async FIFO read-pointer controller.
//   ptr_width()    : pointer width for a given memory address width (one
//                    extra MSB distinguishes full from empty).
//   bin_to_gray()  : binary -> gray conversion on a CONV_WIDTH-bit container.
//   gray_to_bin()  : gray -> binary conversion on a CONV_WIDTH-bit container.
// Callers cast narrower pointers into the container and slice the result
// back; zero upper bits do not disturb either conversion.
// ----------------------------------------------------------------------------
package rptr_ctrl_pkg;

    localparam int CONV_WIDTH = 32;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic logic [CONV_WIDTH-1:0] bin_to_gray(input logic [CONV_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [CONV_WIDTH-1:0] gray_to_bin(input logic [CONV_WIDTH-1:0] g);
        logic [CONV_WIDTH-1:0] b;
        b[CONV_WIDTH-1] = g[CONV_WIDTH-1];
        for (int i = CONV_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rptr_ctrl_if.sv
// ----------------------------------------------------------------------------
// rptr_ctrl_if
// Read-side bundle between the read-domain consumer and rptr_ctrl.
//   master : drives rinc, rflush, rclr_err, rq2_wptr; observes the rest.
//   slave  : rptr_ctrl side.
//
// Handshake: rinc is a pop request. It is accepted on a rising rclk edge
// where rempty=0 and rflush=0; the consumer may hold rinc high across
// cycles and each accepting edge pops one entry. A request on an edge with
// rempty=1 is not accepted and sets the sticky runderflow flag instead.
// ----------------------------------------------------------------------------
interface rptr_ctrl_if
    import rptr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 3
);
    localparam int PW = ptr_width(ADDR_WIDTH);

    logic                  rinc;
    logic                  rflush;
    logic                  rclr_err;
    logic [PW-1:0]         rq2_wptr;
    logic [PW-1:0]         rptr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [PW-1:0]         rlevel;
    logic                  rempty;
    logic                  ralmost_empty;
    logic                  runderflow;

    modport master (
        output rinc, rflush, rclr_err, rq2_wptr,
        input  rptr, raddr, rlevel, rempty, ralmost_empty, runderflow
    );

    modport slave (
        input  rinc, rflush, rclr_err, rq2_wptr,
        output rptr, raddr, rlevel, rempty, ralmost_empty, runderflow
    );

endinterface

// File: rtl/rptr_ctrl_g2b_conv.sv
// ----------------------------------------------------------------------------
// rptr_ctrl_g2b_conv
// Combinational gray -> binary converter, parametrised width.
//   gray : gray-coded input  (WIDTH bits)
//   bin  : binary output     (WIDTH bits)
// Each binary bit is the XOR of all gray bits at or above it, written as
// independent reductions so no bit depends on another output bit.
// ----------------------------------------------------------------------------
module rptr_ctrl_g2b_conv #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/rptr_ctrl.sv
// ----------------------------------------------------------------------------
// rptr_ctrl
// Read-side pointer controller for the async FIFO (read clock domain).
// Ports:
//   rclk  : read-domain clock, all state updates on posedge
//   rrst  : synchronous active-high reset
//   bus   : rptr_ctrl_if.slave
//           in : rinc (pop), rflush (drop unread data), rclr_err (clear
//                underflow), rq2_wptr (synchronised gray write pointer)
//           out: rptr (gray read pointer), raddr (memory read address),
//                rlevel (fill level), rempty, ralmost_empty, runderflow
// Flags and level are computed from the next read pointer so that a pop
// of the last visible entry raises rempty on the same edge.
// ----------------------------------------------------------------------------
module rptr_ctrl
    import rptr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int AE_THRESH  = 1
) (
    input  logic        rclk,
    input  logic        rrst,
    rptr_ctrl_if.slave  bus
);

    localparam int PW = ptr_width(ADDR_WIDTH);

    // Registered state
    logic [PW-1:0] rbin_q;
    logic [PW-1:0] rptr_q;
    logic [PW-1:0] rlevel_q;
    logic          rempty_q;
    logic          ralmost_empty_q;
    logic          runderflow_q;

    // Next-state values
    logic [PW-1:0] wbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] level_next;
    logic          rempty_next;
    logic          ralmost_empty_next;
    logic          runderflow_next;

    rptr_ctrl_g2b_conv #(.WIDTH(PW)) u_g2b (
        .gray (bus.rq2_wptr),
        .bin  (wbin)
    );

    always_comb begin
        rbin_next       = rbin_q;
        runderflow_next = runderflow_q;

        // Flush wins over a pop in the same cycle.
        if (bus.rflush) begin
            rbin_next = wbin;
        end else if (bus.rinc && !rempty_q) begin
            rbin_next = rbin_q + PW'(1);
        end

        rgray_next         = PW'(bin_to_gray(CONV_WIDTH'(rbin_next)));
        rempty_next        = (rgray_next == bus.rq2_wptr);
        // Modulo subtraction; pointers differing only in MSB give a full count.
        level_next         = wbin - rbin_next;
        ralmost_empty_next = (level_next <= PW'(AE_THRESH));

        // Clearing beats a same-cycle underflow; a flush cycle never underflows.
        if (bus.rclr_err) begin
            runderflow_next = 1'b0;
        end else if (bus.rinc && rempty_q && !bus.rflush) begin
            runderflow_next = 1'b1;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_q          <= '0;
            rptr_q          <= '0;
            rlevel_q        <= '0;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            runderflow_q    <= 1'b0;
        end else begin
            rbin_q          <= rbin_next;
            rptr_q          <= rgray_next;
            rlevel_q        <= level_next;
            rempty_q        <= rempty_next;
            ralmost_empty_q <= ralmost_empty_next;
            runderflow_q    <= runderflow_next;
        end
    end

    assign bus.rptr          = rptr_q;
    assign bus.raddr         = rbin_q[ADDR_WIDTH-1:0];
    assign bus.rlevel        = rlevel_q;
    assign bus.rempty        = rempty_q;
    assign bus.ralmost_empty = ralmost_empty_q;
    assign bus.runderflow    = runderflow_q;

endmodule

// File: doc/rptr_ctrl.md
# rptr_ctrl

Parametrised read-side pointer controller for the async FIFO, next generation of the read-pointer handler. It lives in the read clock domain. It takes the two-flop-synchronised gray write pointer and produces the registered gray read pointer, the memory read address, a look-ahead empty flag and a fill level. It adds an almost-empty flag, a sticky underflow flag and a flush that discards all unread data.

## Interface
- ADDR_WIDTH, 3: memory address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AE_THRESH, 1: almost-empty threshold; ralmost_empty asserted while level <= AE_THRESH; legal range 0..2**ADDR_WIDTH-1.
- rclk  in  1  read-domain clock; all state updates on posedge.
- rrst  in  1  synchronous, active-high reset.
- rinc  in  1  pop request; honoured only when rempty=0.
- rflush  in  1  discard all unread entries (read pointer jumps to synchronised write pointer).
- rclr_err  in  1  clears runderflow.
- rq2_wptr  in  ADDR_WIDTH+1  gray write pointer, already synchronised into rclk.
- rptr  out  ADDR_WIDTH+1  registered gray read pointer, to the write-side synchroniser.
- raddr  out  ADDR_WIDTH  memory read address = low ADDR_WIDTH bits of binary read pointer.
- rlevel  out  ADDR_WIDTH+1  registered entry count as seen by read side, 0..2**ADDR_WIDTH.
- rempty  out  1  registered empty flag.
- ralmost_empty  out  1  registered almost-empty flag.
- runderflow  out  1  sticky: pop attempted while empty.

## Operation
- State: rbin (binary read pointer, ADDR_WIDTH+1), rptr, rlevel, rempty, ralmost_empty, runderflow.
- wbin = gray-to-binary(rq2_wptr), combinational.
- rbin_next: rflush=1 -> wbin; else rinc & ~rempty -> rbin+1 (modulo 2**(ADDR_WIDTH+1)); else rbin.
- Each edge: rbin <= rbin_next; rptr <= binary-to-gray(rbin_next); rempty <= (binary-to-gray(rbin_next) == rq2_wptr); rlevel <= (wbin - rbin_next) mod 2**(ADDR_WIDTH+1); ralmost_empty <= level_next <= AE_THRESH.
- raddr driven directly from rbin register bits, with no extra logic.
- Underflow: rinc & rempty & ~rflush -> runderflow <= 1. Pointer unchanged. Held until rclr_err.
- rclr_err has priority over a same-cycle new underflow; runderflow <= 0.
- rflush overrides rinc; no pop and no underflow that cycle.
- Wrap: the extra MSB toggles each pass through the memory; level = 2**ADDR_WIDTH when pointers differ only in MSB.
- Reset (rrst=1 at edge, any state, mid-operation included): rbin=0, rptr=0, raddr=0, rlevel=0, rempty=1, ralmost_empty=1, runderflow=0. Reset overrides all inputs.

## Timing
- Pop latency: raddr advances on the edge that samples rinc=1 & rempty=0.
- rempty is look-ahead: computed from rbin_next. The pop that consumes the last visible entry sets rempty on the same edge, so no extra-pop window exists.
- New writes appear as rempty=0 / rlevel increase one rclk edge after rq2_wptr changes. Synchroniser latency is external.
- rflush: rempty=1 and rlevel=0 on the next edge, unless rq2_wptr also moved that cycle; level then reflects it next edge.
- rlevel is pessimistic (never over-reports) because rq2_wptr lags the true write pointer.

## Structure
- Shared fifo_pkg: gray/binary conversion functions, pointer-width helper (ADDR_WIDTH+1).
- Reuse existing b2g_conv for rptr generation.
- New sub-module g2b_conv (parametrised WIDTH, XOR-prefix chain) for wbin.
- Single always block for registers, with separate combinational next-state logic.

## Test plan
ADDR_WIDTH=3, AE_THRESH=2 unless noted.
- Reset: rrst=1 two edges, rq2_wptr=0 -> rptr=0, raddr=0, rlevel=0, rempty=1, ralmost_empty=1, runderflow=0.
- Fill/drain: rq2_wptr=gray(3)=0010. Next edge -> rempty=0, rlevel=3, ralmost_empty=0. Pop 3 cycles -> raddr 1,2,3; rlevel 2,1,0; ralmost_empty=1 after first pop; rempty=1 on third pop edge.
- Wrap/full: rbin=0, rq2_wptr=gray(8)=1100 -> rlevel=8. Pop 8 -> raddr 7->0, rptr=1100, rempty=1. Then rq2_wptr=gray(9)=1101 -> rlevel=1.
- Underflow: rempty=1, rinc=1 one cycle -> rbin unchanged, runderflow=1 next edge and held 10 cycles; rclr_err=1 -> runderflow=0 next edge.
- Flush: rlevel=5, rflush=1 and rinc=1 same cycle -> next edge rbin=wbin, rempty=1, rlevel=0, runderflow stays 0.
- Reset mid-operation: rlevel=4, rinc=1, rrst=1 -> next edge all outputs at reset values; pop ignored.
